// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES inverse cipher: one inverse round per cycle, round keys read in descending order.
// Latency NR+2 cycles accept-to-out_valid; out_valid holds with stable data until out_ready.
module aes_inv_cipher_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         key_ready,
  output logic         rk_rd,
  output logic [3:0]   rk_addr,
  input  logic [127:0] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  typedef enum logic [2:0] {IDLE, ADDK, ROUND, FINAL, DONE} state_t;

  localparam logic [3:0] NR_L  = 4'(NR);
  localparam logic [3:0] NR_M1 = 4'(NR - 1);

  state_t       state, state_nxt;
  logic [127:0] st, st_nxt;
  logic [3:0]   rnd, rnd_nxt;
  logic [3:0]   addr_q, addr_nxt;
  logic         accept;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gmul(r, r);
      if (i != 0) r = gmul(r, x);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] a;
    a = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gf_inv(a);
  endfunction

  // Byte i = row (i%4), column (i/4); row r rotates right by r columns.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    int src;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = r + 4 * ((c - r + 4) % 4);
        o[127-8*(r+4*c) -: 8] = s[127-8*src -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  assign in_ready  = (state == IDLE) && key_ready;
  assign accept    = in_ready && in_valid && !rst;
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = st;
  assign rk_addr   = rk_rd ? addr_nxt : addr_q;

  // rk_data always belongs to the address issued in the previous cycle.
  always_comb begin
    state_nxt = state;
    st_nxt    = st;
    rnd_nxt   = rnd;
    addr_nxt  = addr_q;
    rk_rd     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          st_nxt    = in_data;
          rk_rd     = 1'b1;
          addr_nxt  = NR_L;
          state_nxt = ADDK;
        end
      end
      ADDK: begin
        st_nxt    = st ^ rk_data;
        rk_rd     = 1'b1;
        addr_nxt  = NR_M1;
        rnd_nxt   = NR_M1;
        state_nxt = ROUND;
      end
      ROUND: begin
        st_nxt   = inv_mix_columns(inv_sub_bytes(inv_shift_rows(st)) ^ rk_data);
        rk_rd    = 1'b1;
        addr_nxt = rnd - 4'd1;
        if (rnd > 4'd1) rnd_nxt = rnd - 4'd1;
        else            state_nxt = FINAL;
      end
      FINAL: begin
        st_nxt    = inv_sub_bytes(inv_shift_rows(st)) ^ rk_data;
        state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) rk_rd = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      st     <= '0;
      rnd    <= '0;
      addr_q <= '0;
    end else begin
      state  <= state_nxt;
      st     <= st_nxt;
      rnd    <= rnd_nxt;
      addr_q <= rk_rd ? addr_nxt : addr_q;
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
// Bench for aes_inv_cipher_ctrl: NR=10 and NR=14 instances, scoreboard of expected plaintexts.
module tb_aes_inv_cipher_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, key_ready, out_ready, sel14;
  logic [127:0] in_data;

  logic         in_ready10, rk_rd10, out_valid10, busy10;
  logic [3:0]   rk_addr10;
  logic [127:0] rk_data10, out_data10;
  logic         in_ready14, rk_rd14, out_valid14, busy14;
  logic [3:0]   rk_addr14;
  logic [127:0] rk_data14, out_data14;

  logic [127:0] rk10 [0:14];
  logic [127:0] rk14 [0:14];

  aes_inv_cipher_ctrl #(.NR(10)) u_dut10 (
    .clk(clk), .rst(rst), .in_valid(in_valid & ~sel14), .in_ready(in_ready10),
    .in_data(in_data), .key_ready(key_ready), .rk_rd(rk_rd10), .rk_addr(rk_addr10),
    .rk_data(rk_data10), .out_valid(out_valid10), .out_ready(out_ready),
    .out_data(out_data10), .busy(busy10)
  );

  aes_inv_cipher_ctrl #(.NR(14)) u_dut14 (
    .clk(clk), .rst(rst), .in_valid(in_valid & sel14), .in_ready(in_ready14),
    .in_data(in_data), .key_ready(key_ready), .rk_rd(rk_rd14), .rk_addr(rk_addr14),
    .rk_data(rk_data14), .out_valid(out_valid14), .out_ready(out_ready),
    .out_data(out_data14), .busy(busy14)
  );

  // Round-key stores: data returned one cycle after the read strobe.
  always @(posedge clk) begin
    if (rk_rd10) rk_data10 <= rk10[rk_addr10];
    if (rk_rd14) rk_data14 <= rk14[rk_addr14];
  end

  logic         m_in_ready, m_rk_rd, m_out_valid, m_busy;
  logic [3:0]   m_rk_addr;
  logic [127:0] m_out_data;
  assign m_in_ready  = sel14 ? in_ready14  : in_ready10;
  assign m_rk_rd     = sel14 ? rk_rd14     : rk_rd10;
  assign m_rk_addr   = sel14 ? rk_addr14   : rk_addr10;
  assign m_out_valid = sel14 ? out_valid14 : out_valid10;
  assign m_out_data  = sel14 ? out_data14  : out_data10;
  assign m_busy      = sel14 ? busy14      : busy10;

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT3 = 128'h8ea2b7ca516745bfeafc49904b496089;

  int checks, failures;
  int cyc, acc_cyc, rd_last, rd_exp, rd_cnt;
  bit first_out, acc_seen, b2b, have_prev;
  logic [127:0] cur_pt;
  logic [127:0] exp_q [$];

  // ---------------- forward AES reference ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 0; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v;
    v = 8'h01;
    for (int i = 0; i < 254; i++) v = gm(v, x);
    return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    int src;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        src = r + 4 * ((c + r) % 4);
        o[127-8*(r+4*c) -: 8] = sbox(s[127-8*src -: 8]);
      end
    return o;
  endfunction

  function automatic logic [127:0] mixc(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
      o[103-32*c -: 8] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
    end
    return o;
  endfunction

  function automatic logic [127:0] enc10(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rk10[0];
    for (int r = 1; r < 10; r++) s = mixc(sub_shift(s)) ^ rk10[r];
    return sub_shift(s) ^ rk10[10];
  endfunction

  task automatic expand(input logic [255:0] key, input int nk);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) begin
      if (nk == 4) rk10[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      else         rk14[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called once per cycle at the falling edge; owns the scoreboard.
  task automatic mon();
    int nr;
    bit acc;
    nr = sel14 ? 14 : 10;
    acc = in_valid && m_in_ready && !rst;
    acc_seen = 0;
    if (rst) begin
      exp_q.delete();
      rd_exp = -1;
      first_out = 0;
    end else begin
      if (acc) begin
        exp_q.push_back(cur_pt);
        if (b2b && have_prev) chk("accept_period", cyc - acc_cyc, nr + 3);
        have_prev = b2b;
        acc_cyc = cyc;
        rd_exp = nr;
        rd_cnt = 0;
        first_out = 1;
        acc_seen = 1;
      end
      if (m_rk_rd) begin
        chk("rk_addr", m_rk_addr, rd_exp);
        if (!acc) chk("rk_consecutive", cyc, rd_last + 1);
        rd_last = cyc;
        rd_exp--;
        rd_cnt++;
      end
      if (m_out_valid && first_out) begin
        chk("latency", cyc - acc_cyc, nr + 2);
        chk("rk_count", rd_cnt, nr + 1);
        first_out = 0;
      end
      if (m_out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_out", 1, 0);
        else                   chk("out_data", m_out_data, exp_q.pop_front());
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [127:0] ct, input logic [127:0] pt);
    int n;
    cur_pt = pt; in_data = ct; in_valid = 1'b1; n = 0;
    step();
    while (!acc_seen && n < 40) begin step(); n++; end
    if (!acc_seen) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin step(); n++; end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    logic [127:0] pt;
    checks = 0; failures = 0; cyc = 0; acc_cyc = 0; rd_last = 0;
    rd_exp = -1; rd_cnt = 0; first_out = 0; acc_seen = 0; b2b = 0; have_prev = 0;
    cur_pt = '0; rst = 1'b1; in_valid = 1'b0; key_ready = 1'b0; out_ready = 1'b1;
    sel14 = 1'b0; in_data = '0;
    for (int r = 0; r < 15; r++) begin rk10[r] = '0; rk14[r] = '0; end
    expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
    expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);

    // Reset, with a simultaneous valid offer that must be ignored.
    step(); step();
    in_valid = 1'b1; key_ready = 1'b1; in_data = CT1; cur_pt = PT;
    step();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("rst_busy10", busy10, 0);
    chk("rst_busy14", busy14, 0);
    chk("rst_out_valid", out_valid10, 0);
    chk("rst_rk_rd", rk_rd10, 0);
    chk("rst_rk_addr", rk_addr10, 0);
    chk("rst_out_data", out_data10, 0);
    chk("rst_in_ready_hi", in_ready10, 1);
    key_ready = 1'b0;
    #1;
    chk("rst_in_ready_lo", in_ready10, 0);
    key_ready = 1'b1;

    // FIPS-197 C.1
    send(CT1, PT);
    drain();

    // Backpressure
    out_ready = 1'b0;
    send(CT1, PT);
    n = 0;
    while (!m_out_valid && n < 30) begin step(); n++; end
    chk("bp_valid_seen", m_out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid_hold", m_out_valid, 1);
      chk("bp_data_hold", m_out_data, PT);
      chk("bp_in_ready", m_in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    chk("bp_idle_busy", m_busy, 0);
    chk("bp_idle_valid", m_out_valid, 0);
    drain();

    // Accept gating by key_ready, then garbage offered while busy
    key_ready = 1'b0; cur_pt = PT; in_data = CT1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("gate_in_ready", m_in_ready, 0);
      chk("gate_rk_rd", m_rk_rd, 0);
      step();
    end
    key_ready = 1'b1;
    #1;
    chk("gate_open", m_in_ready, 1);
    step();
    chk("gate_accept", acc_seen, 1);
    for (int i = 0; i < 8; i++) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      step();
      chk("busy_in_ready", m_in_ready, 0);
    end
    in_valid = 1'b0;
    drain();

    // Reset in cycle 6 after accept
    send(CT1, PT);
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_busy", m_busy, 0);
    chk("midrst_out_valid", m_out_valid, 0);
    chk("midrst_rk_rd", m_rk_rd, 0);
    chk("midrst_rk_addr", m_rk_addr, 0);
    for (int i = 0; i < 14; i++) step();
    chk("midrst_no_output", m_out_valid, 0);
    send(CT1, PT);
    drain();

    // NR=14, FIPS-197 C.3; key_ready dropping mid-block must not abort it
    sel14 = 1'b1;
    send(CT3, PT);
    key_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    key_ready = 1'b1;
    drain();
    sel14 = 1'b0;

    // Back-to-back random blocks, out_ready tied high
    b2b = 1; have_prev = 0;
    for (int k = 0; k < 20; k++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      send(enc10(pt), pt);
    end
    drain();
    b2b = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_inv_cipher_ctrl.md
# aes_inv_cipher_ctrl

Iterative AES inverse-cipher sequencer. It accepts one 128-bit ciphertext block and fetches round keys from an external round-key store in descending order. It applies one inverse round per cycle, built from the team's combinational inverse round functions (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns), and returns the plaintext over a valid/ready handshake. It sits between the block-level decrypt interface and the shared round-key RAM.

## Interface
- NR, 10, number of rounds. Legal values are 10, 12 and 14 (AES-128/192/256). Every round key is 128 bits.
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  ciphertext offered
- in_ready  out  1  block can accept ciphertext
- in_data  in  128  ciphertext, byte 0 in [127:120]
- key_ready  in  1  round-key store fully loaded
- rk_rd  out  1  round-key read strobe
- rk_addr  out  4  round-key index, 0..NR
- rk_data  in  128  round key, valid exactly one cycle after the rk_rd/rk_addr cycle
- out_valid  out  1  plaintext available
- out_ready  in  1  consumer accepts plaintext
- out_data  out  128  plaintext, same byte order as in_data
- busy  out  1  high in every state except IDLE

## Operation
- Internal registers:
  - 128-bit state register `st`.
  - 4-bit round counter `rnd`.
  - FSM with states IDLE, ADDK, ROUND, FINAL, DONE.
- in_ready = (IDLE && key_ready). An accept is in_valid && in_ready.
- IDLE:
  - On accept: `st` <= in_data; rk_rd=1 with rk_addr=NR; go to ADDK.
  - Otherwise rk_rd=0.
- ADDK:
  - `st` <= `st` ^ rk_data.
  - Issue rk_addr=NR-1 (rk_rd=1) and set `rnd` <= NR-1.
  - Go to ROUND.
- ROUND:
  - `st` <= InvMixColumns(InvSubBytes(InvShiftRows(`st`)) ^ rk_data).
  - If `rnd` > 1: issue rk_addr=`rnd`-1, decrement `rnd`, stay in ROUND.
  - If `rnd` == 1: issue rk_addr=0 and go to FINAL.
- FINAL:
  - `st` <= InvSubBytes(InvShiftRows(`st`)) ^ rk_data.
  - rk_rd=0; go to DONE.
- DONE:
  - out_valid=1, out_data=`st`.
  - On out_ready go to IDLE. Otherwise hold with out_data stable.
- rk_rd is high exactly NR+1 cycles per block, with addresses NR, NR-1, …, 0 strictly descending. No other reads are issued.
- in_valid while not in IDLE is ignored; in_data is not sampled.
- key_ready is sampled only in IDLE. Deassertion during an operation does not abort it; the key store owner must not rewrite keys while busy=1.
- out_data is driven from `st` at all times. It is meaningful only while out_valid=1.
- rk_addr holds its last value when rk_rd=0.

## Timing
- Reset values:
  - FSM = IDLE, `st` = 0, `rnd` = 0, rk_addr = 0.
  - out_valid = 0, rk_rd = 0, busy = 0.
  - in_ready = key_ready (combinational).
- Cycle numbering: accept edge is cycle 0, then ADDK is cycle 1, ROUND covers cycles 2..NR, FINAL is cycle NR+1, and DONE is entered at cycle NR+2.
- Latency from accept to out_valid is NR+2 cycles: 12 for NR=10, 16 for NR=14.
- The earliest next accept is the cycle after the DONE handshake. Minimum period is NR+3 cycles per block.
- in_ready is 0 from the cycle after accept until return to IDLE.
- Reset mid-operation (any state): the next cycle is IDLE with all outputs at reset values. No partial plaintext is presented and no further rk_rd is issued.
- Simultaneous rst and in_valid: rst wins and nothing is accepted.
- Simultaneous out_ready and in_valid in DONE: the handshake completes and the block goes to IDLE. The new block is accepted no earlier than the following cycle.

## Test plan
- FIPS-197 C.1, NR=10, key store loaded with the expansion of 000102…0f. Stimulus: in_data=69c4e0d86a7b0430d8cdb78070b4c55a. Required response: out_data=00112233445566778899aabbccddeeff, out_valid 12 cycles after accept, rk_addr sequence 10..0 on 11 consecutive cycles.
- Backpressure, same vector: hold out_ready=0 for 5 cycles after out_valid. Required: out_valid and out_data stay stable, in_ready=0, and IDLE is entered the cycle after out_ready=1.
- Accept gating and busy-time input: hold key_ready=0 with in_valid=1 for 4 cycles and require in_ready=0 and no rk_rd. Then raise key_ready and require an accept on that cycle. While busy, drive in_valid=1 with garbage data and require the result to still be the C.1 plaintext.
- Reset mid-operation: assert rst at cycle 6 after accept. Required: next cycle busy=0, out_valid=0, rk_rd=0. A fresh C.1 block then decrypts correctly.
- NR=14, FIPS-197 C.3, key expansion of 000102…1f. Stimulus: in_data=8ea2b7ca516745bfeafc49904b496089. Required response: out_data=00112233445566778899aabbccddeeff with latency 16.
- Back-to-back: 20 random blocks with out_ready tied high. Required: matches the reference model, exactly NR+3 cycles between accepts, and rk_rd count = 11 per block.
